// File: rtl/gpi_debounce_pkg.sv
// Shared types and constants for the GPI input debouncer.
package gpi_debounce_pkg;

   typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} db_state_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/gpi_debounce_ch.sv
// One debounce channel: 2-FF synchronizer, stability FSM, level and edge-pulse registers.
// GPI_DEBOUNCE_BYPASS_EN replaces the FSM with a plain synchronizer plus edge detect.
//
// state   | meaning
// --------+---------------------------------------------------------
// LO      | accepted level 0, db_out=0
// WAIT_HI | s is 1, counting ticks until the high level is accepted
// HI      | accepted level 1, db_out=1
// WAIT_LO | s is 0, counting ticks until the low level is accepted
module gpi_debounce_ch
   import gpi_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_raw,
   input  logic tick,
   output logic db_out,
   output logic rise,
   output logic fall
);

   logic s_meta;
   logic s_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         s_meta <= din_raw;
         s_sync <= s_meta;
      end
   end

`ifdef GPI_DEBOUNCE_BYPASS_EN

   logic s_dly;
   logic unused_tick;

   assign unused_tick = tick;
   assign db_out      = s_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_dly <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s_dly <= s_sync;
         rise  <= s_sync & ~s_dly;
         fall  <= ~s_sync & s_dly;
      end
   end

`else

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   // A level change on s always takes priority over a completing tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= LO;
         cnt    <= '0;
         db_out <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            LO: begin
               if (s_sync) begin
                  state <= WAIT_HI;
                  cnt   <= '0;
               end
            end
            WAIT_HI: begin
               if (!s_sync) begin
                  state <= LO;
               end else if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state  <= HI;
                     db_out <= 1'b1;
                     rise   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HI: begin
               if (!s_sync) begin
                  state <= WAIT_LO;
                  cnt   <= '0;
               end
            end
            WAIT_LO: begin
               if (s_sync) begin
                  state <= HI;
               end else if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state  <= LO;
                     db_out <= 1'b0;
                     fall   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= LO;
               cnt   <= '0;
            end
         endcase
      end
   end

`endif

endmodule

// File: rtl/gpi_debounce.sv
// Multi-channel switch/button conditioner feeding the GPI core din bus.
// Defining GPI_DEBOUNCE_BYPASS_EN drops the prescaler and FSMs for fast simulation.
module gpi_debounce
   import gpi_debounce_pkg::*;
#(
   parameter int N_SW         = 4,
   parameter int TICK_W       = 20,
   parameter int STABLE_TICKS = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] din_raw,
   output logic [N_SW-1:0] db_out,
   output logic [N_SW-1:0] rise,
   output logic [N_SW-1:0] fall
);

   logic tick;

`ifdef GPI_DEBOUNCE_BYPASS_EN

   assign tick = 1'b0;

`else

   logic [TICK_W-1:0] presc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign tick = &presc;

`endif

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      gpi_debounce_ch #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .din_raw(din_raw[i]),
         .tick   (tick),
         .db_out (db_out[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

endmodule

// File: tb/tb_gpi_debounce.sv
// Self-checking bench for gpi_debounce: expected pulses go into a queue with an
// acceptance window and are matched by a monitor as the DUT emits them.
module tb_gpi_debounce;

   localparam int N_SW   = 4;
   localparam int TICK_W = 2;
   localparam int STABLE = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N_SW-1:0] din_raw;
   logic [N_SW-1:0] db_out;
   logic [N_SW-1:0] rise;
   logic [N_SW-1:0] fall;

   typedef struct {
      int ch;
      bit is_rise;
      int lo;
      int hi;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int presc_m  = 0;
   int last_rise_cyc [N_SW];
   int last_fall_cyc [N_SW];
   logic [N_SW-1:0] prev_rise = '0;
   logic [N_SW-1:0] prev_fall = '0;

   always #5 clk = ~clk;

   gpi_debounce #(
      .N_SW        (N_SW),
      .TICK_W      (TICK_W),
      .STABLE_TICKS(STABLE)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_raw(din_raw),
      .db_out (db_out),
      .rise   (rise),
      .fall   (fall)
   );

   // Pulse monitor: every pulse must match a queued expectation inside its window.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (rst_n) presc_m = (presc_m + 1) % 4;
         else       presc_m = 0;
         #1;
         for (int ch = 0; ch < N_SW; ch++) begin
            if (rise[ch] && fall[ch]) begin
               n_checks++;
               n_fail++;
               $display("FAIL rise_fall_both ch%0d cycle %0d: got rise=1 fall=1, required at most one", ch, cyc);
            end
            for (int k = 0; k < 2; k++) begin
               logic p;
               logic pp;
               int   idx;
               p   = (k == 1) ? rise[ch] : fall[ch];
               pp  = (k == 1) ? prev_rise[ch] : prev_fall[ch];
               idx = -1;
               if (p) begin
                  n_checks++;
                  if (pp) begin
                     n_fail++;
                     $display("FAIL pulse_width ch%0d %s cycle %0d: got pulse longer than 1 cycle, required 1",
                              ch, (k == 1) ? "rise" : "fall", cyc);
                  end else begin
                     for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].ch == ch && exp_q[i].is_rise == (k == 1)) idx = i;
                     end
                     if (idx < 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pulse ch%0d %s cycle %0d: got pulse, required none",
                                 ch, (k == 1) ? "rise" : "fall", cyc);
                     end else begin
                        if (cyc < exp_q[idx].lo || cyc > exp_q[idx].hi) begin
                           n_fail++;
                           $display("FAIL pulse_window ch%0d %s: got cycle %0d, required %0d..%0d",
                                    ch, (k == 1) ? "rise" : "fall", cyc, exp_q[idx].lo, exp_q[idx].hi);
                        end
                        exp_q.delete(idx);
                     end
                     n_checks++;
                     if (db_out[ch] !== (k == 1)) begin
                        n_fail++;
                        $display("FAIL level_with_pulse ch%0d cycle %0d: got db_out=%0b, required %0b",
                                 ch, cyc, db_out[ch], (k == 1));
                     end
                     if (k == 1) last_rise_cyc[ch] = cyc;
                     else        last_fall_cyc[ch] = cyc;
                  end
               end
            end
         end
         prev_rise = rise;
         prev_fall = fall;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "timeout");
   end

   task automatic expect_pulse(input int ch, input bit is_rise, input int e0);
      exp_t e;
      e.ch      = ch;
      e.is_rise = is_rise;
      e.lo      = e0 + 11;
      e.hi      = e0 + 14;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_pulse: got %0d expected pulses still pending, required 0", exp_q.size());
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic align_phase(input int p);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (presc_m == p) break;
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      din_raw = 4'hF;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (db_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got db_out=%h rise=%h fall=%h, required 0/0/0", db_out, rise, fall);
         end
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (db_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: got db_out=%h, required 0", db_out);
         end
      end
      din_raw = 4'h0;
      repeat (15) @(negedge clk);
      n_checks++;
      if (db_out !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_short_high: got db_out=%h, required 0", db_out);
      end
   endtask

   task automatic test_clean_press();
      int e0;
      @(negedge clk);
      din_raw[0] = 1'b1;
      e0 = cyc + 1;
      expect_pulse(0, 1'b1, e0);
      wait_drain(30);
      n_checks++;
      if (db_out !== 4'b0001) begin
         n_fail++;
         $display("FAIL clean_press_level: got db_out=%h, required 1", db_out);
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         din_raw[1] = (i % 2 == 0);
         repeat (2) @(negedge clk);
      end
      repeat (30) @(negedge clk);
      n_checks++;
      if (db_out !== 4'b0001) begin
         n_fail++;
         $display("FAIL bounce_reject: got db_out=%h, required 1", db_out);
      end
   endtask

   // The drop of s lands on the very edge whose tick would complete the window.
   task automatic test_tick_collision();
      align_phase(0);
      din_raw[3] = 1'b1;
      repeat (9) @(negedge clk);
      din_raw[3] = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (db_out !== 4'b0001) begin
         n_fail++;
         $display("FAIL tick_collision: got db_out=%h, required 1", db_out);
      end
   endtask

   task automatic test_late_glitch();
      int e1;
      align_phase(1);
      din_raw[2] = 1'b1;
      repeat (10) @(negedge clk);
      din_raw[2] = 1'b0;
      @(negedge clk);
      din_raw[2] = 1'b1;
      e1 = cyc + 1;
      expect_pulse(2, 1'b1, e1);
      wait_drain(40);
      n_checks++;
      if (db_out !== 4'b0101) begin
         n_fail++;
         $display("FAIL late_glitch_level: got db_out=%h, required 5", db_out);
      end
   endtask

   task automatic test_release_multi();
      @(negedge clk);
      din_raw[3] = 1'b1;
      expect_pulse(3, 1'b1, cyc + 1);
      wait_drain(30);
      @(negedge clk);
      din_raw[2] = 1'b0;
      expect_pulse(2, 1'b0, cyc + 1);
      wait_drain(30);
      n_checks++;
      if (db_out !== 4'b1001) begin
         n_fail++;
         $display("FAIL multi_before_release: got db_out=%h, required 9", db_out);
      end
      @(negedge clk);
      din_raw[0] = 1'b0;
      din_raw[3] = 1'b0;
      expect_pulse(0, 1'b0, cyc + 1);
      expect_pulse(3, 1'b0, cyc + 1);
      wait_drain(30);
      n_checks++;
      if (last_fall_cyc[0] !== last_fall_cyc[3]) begin
         n_fail++;
         $display("FAIL multi_fall_same_cycle: got ch0 at %0d ch3 at %0d, required equal",
                  last_fall_cyc[0], last_fall_cyc[3]);
      end
      n_checks++;
      if (db_out !== 4'h0) begin
         n_fail++;
         $display("FAIL multi_release_level: got db_out=%h, required 0", db_out);
      end
   endtask

   task automatic test_reset_mid_wait();
      int e0;
      @(negedge clk);
      din_raw[0] = 1'b1;
      expect_pulse(0, 1'b1, cyc + 1);
      wait_drain(30);
      @(negedge clk);
      din_raw[1] = 1'b1;
      repeat (5) @(negedge clk);
      rst_n      = 1'b0;
      din_raw[0] = 1'b0;
      presc_m    = 0;
      #1;
      n_checks++;
      if (db_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_async_clear: got db_out=%h rise=%h fall=%h, required 0/0/0", db_out, rise, fall);
      end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (db_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got db_out=%h, required 0", db_out);
         end
      end
      rst_n = 1'b1;
      e0 = cyc + 1;
      expect_pulse(1, 1'b1, e0);
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (db_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got db_out=%h, required 0", db_out);
         end
      end
      wait_drain(30);
      n_checks++;
      if (db_out !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_mid_restart: got db_out=%h, required 2", db_out);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_tick_collision();
      test_late_glitch();
      test_release_multi();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
